// File: rtl/f1_pkg.sv
// rtl/f1_pkg.sv - shared states, constants and hold-load helper for the F1 start sequencer
package f1_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

   localparam logic [7:0] LIGHTS_OFF          = 8'h00;
   localparam logic [7:0] LIGHTS_ALL_ON       = 8'hFF;
   localparam logic [6:0] LFSR_SEED           = 7'h01;
   localparam int         TICK_CYCLES_DEFAULT = 4;
   localparam int         TICK_W              = 16;
   localparam int         HOLD_W              = 15;

   // 7-bit value shifted by up to 8 still fits the 15-bit hold counter.
   function automatic logic [HOLD_W-1:0] hold_load(input logic [6:0] v, input int unsigned shift);
      logic [HOLD_W-1:0] w;
      w = {{(HOLD_W-7){1'b0}}, v};
      return w << shift;
   endfunction

endpackage

// File: rtl/f1_en_sequencer_if.sv
// rtl/f1_en_sequencer_if.sv - trigger/lights/en/go/busy bundle between driver and sequencer
interface f1_en_sequencer_if;
   logic       trigger;
   logic [7:0] lights;
   logic       en;
   logic       go;
   logic       busy;

   modport master (output trigger, output lights, input en, input go, input busy);
   modport slave  (input trigger, input lights, output en, output go, output busy);
endinterface

// File: rtl/lfsr7.sv
// rtl/lfsr7.sv - free-running 7-bit maximal-length LFSR (x^7 + x^6 + 1)
module lfsr7
   import f1_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   output logic [6:0] q
);

   logic [6:0] q_q;
   logic [6:0] q_d;

   always_comb begin
      q_d = {q_q[5:0], q_q[6] ^ q_q[5]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= LFSR_SEED;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/f1_en_sequencer.sv
// rtl/f1_en_sequencer.sv - paces the start-light FSM, then holds a random time before lights-out
module f1_en_sequencer
   import f1_pkg::*;
#(
   parameter int TICK_CYCLES = TICK_CYCLES_DEFAULT,
   parameter int DELAY_SHIFT = 0
) (
   input  logic              clk,
   input  logic              rst,
   f1_en_sequencer_if.slave  bus
);

   localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(TICK_CYCLES - 1);

   state_e              state_q, state_d;
   logic [TICK_W-1:0]   tick_q, tick_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic                en_q, en_d;
   logic                go_q, go_d;
   logic                busy_q, busy_d;
   logic [6:0]          lfsr;

   lfsr7 u_lfsr (
      .clk (clk),
      .rst (rst),
      .q   (lfsr)
   );

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      hold_d  = hold_q;
      en_d    = 1'b0;
      go_d    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.trigger && (bus.lights == LIGHTS_OFF)) begin
               state_d = ST_COUNT;
               tick_d  = TICK_RELOAD;
            end
         end
         ST_COUNT: begin
            // All lights on wins over a coincident tick expiry: no ninth count pulse.
            if (bus.lights == LIGHTS_ALL_ON) begin
               state_d = ST_HOLD;
               hold_d  = hold_load(lfsr, DELAY_SHIFT);
            end else if (tick_q == '0) begin
               tick_d = TICK_RELOAD;
               en_d   = 1'b1;
            end else begin
               tick_d = tick_q - TICK_W'(1);
            end
         end
         ST_HOLD: begin
            if (hold_q == HOLD_W'(1)) begin
               state_d = ST_IDLE;
               hold_d  = '0;
               en_d    = 1'b1;
               go_d    = 1'b1;
            end else begin
               hold_d = hold_q - HOLD_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // The lights-out pulse cycle still reports busy even though state is back in IDLE.
      busy_d = (state_d != ST_IDLE) || go_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         tick_q  <= '0;
         hold_q  <= '0;
         en_q    <= 1'b0;
         go_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         hold_q  <= hold_d;
         en_q    <= en_d;
         go_q    <= go_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.en   = en_q;
   assign bus.go   = go_q;
   assign bus.busy = busy_q;

endmodule

// File: doc/f1_en_sequencer.md
F1_EN_SEQUENCER -- requirements
Module: f1_en_sequencer

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 4: clock cycles between light-advance pulses; legal range 2..2^16.
REQ-002 SHALL have parameter DELAY_SHIFT, default 0: random-hold scaling, hold = lfsr_value << DELAY_SHIFT cycles; legal range 0..8.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset: asynchronous, active-high.
REQ-005 SHALL have port trigger  input  1  start request, sampled each clk.
REQ-006 SHALL have port lights  input  8  light pattern returned by the downstream light FSM.
REQ-007 SHALL have port en  output  1  one-cycle advance pulse to the downstream light FSM.
REQ-008 SHALL have port go  output  1  one-cycle pulse marking lights-out (reaction start).
REQ-009 SHALL have port busy  output  1  high while a start sequence is in progress.

Function
REQ-010 SHALL implement states IDLE, COUNT and HOLD; en, go and busy SHALL be driven directly from flops (no combinational input-to-output path).
REQ-011 IDLE: en=0, go=0, busy=0; trigger=1 with lights==8'h00 SHALL move to COUNT and load tick counter with TICK_CYCLES-1.
REQ-012 trigger in IDLE with lights!=8'h00 SHALL be ignored; trigger in COUNT or HOLD SHALL be ignored.
REQ-013 COUNT: tick counter decrements every cycle; on reaching 0 with lights!=8'hFF, the counter SHALL reload and en SHALL pulse high for exactly one cycle.
REQ-014 First en pulse SHALL be high in cycle TICK_CYCLES after the trigger-sampling edge; subsequent pulses SHALL be spaced exactly TICK_CYCLES cycles apart.
REQ-015 In COUNT, lights==8'hFF SHALL move to HOLD, suppress further COUNT pulses, and load the hold counter with lfsr_value << DELAY_SHIFT.
REQ-016 Hold counter SHALL be 15 bits wide, with no overflow at the legal DELAY_SHIFT maximum.
REQ-017 HOLD: hold counter decrements each cycle; on reaching 1, en and go SHALL pulse high together for exactly one cycle, and state SHALL return to IDLE.
REQ-018 busy SHALL be 1 in COUNT and HOLD, including the cycle in which the final en/go pulse is high.
REQ-019 lfsr SHALL be 7 bits, free-running every cycle in all states, next = {lfsr[5:0], lfsr[6]^lfsr[5]}; period 127; value never 0, so hold is always at least 1 cycle.
REQ-020 lfsr_value used by REQ-015 SHALL be the lfsr contents in the cycle in which lights==8'hFF is first seen in COUNT.
REQ-021 Exactly 9 en pulses (8 in COUNT, 1 in HOLD) SHALL be issued per accepted trigger.

Reset
REQ-022 rst=1 SHALL immediately force state=IDLE, en=0, go=0, busy=0, tick counter=0, hold counter=0, lfsr=7'h01, independent of clk.
REQ-023 Reset asserted mid-COUNT or mid-HOLD SHALL abort the sequence with no further en pulse; the first trigger after release SHALL obey REQ-011/012.

Structure
REQ-024 Shared package f1_pkg SHALL hold the state enum, LIGHTS_OFF=8'h00, LIGHTS_ALL_ON=8'hFF, LFSR_SEED=7'h01, and TICK_CYCLES default.
REQ-025 LFSR SHALL be a separate sub-module lfsr7 (clk, rst, 7-bit q), instantiated once.

Verification
REQ-026 Reset, trigger at cycle 0 with lights model from the light FSM -> en high at cycles 4,8,...,32; lights 8'hFF after 32; busy=1 throughout.
REQ-027 Hold check: reference LFSR model gives lfsr value V at the FF-detect cycle -> single en+go pulse exactly V cycles after HOLD entry; busy falls the next cycle; lights return to 8'h00.
REQ-028 DELAY_SHIFT=3 -> hold length = 8*V cycles; total en count = 9.
REQ-029 Triggers repeated every cycle during COUNT/HOLD, plus trigger with lights=8'h03 in IDLE -> no extra en, no restart.
REQ-030 rst pulsed at cycle 18 (mid-COUNT) and, separately, in mid-HOLD -> en/go/busy drop to 0 immediately; lfsr=7'h01; no pulse until a new trigger.
REQ-031 Free-running LFSR over 127 cycles -> all nonzero 7-bit values appear once; value 0 never appears.
